// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus: ALU/load requests, decode scoreboard queries, regfile write port
interface regfile_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  claim_valid;
  logic [ADDR_WIDTH-1:0] claim_addr;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic                  rs1_busy;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs2_busy;
  logic                  rd_wen;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output claim_valid, claim_addr, rs1_addr, rs2_addr,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy,
    input  rd_wen, rd_addr, rd_data
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  claim_valid, claim_addr, rs1_addr, rs2_addr,
    output alu_ready, mem_ready, rs1_busy, rs2_busy,
    output rd_wen, rd_addr, rd_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester regfile write-port arbiter with pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  wb
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  localparam int CW   = 4;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic {MEM_PRI, ALU_PRI} pri_t;

  pri_t                  state, state_nxt;
  logic [CW-1:0]         wait_cnt, wait_nxt;
  logic [NREG-1:0]       busy, busy_nxt;
  logic                  alu_grant, mem_grant, xfer;
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic [DATA_WIDTH-1:0] xfer_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MEM_PRI;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Grants are gated by rst so neither requester sees a handshake during reset.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!rst) begin
      if (state == ALU_PRI) begin
        alu_grant = wb.alu_valid;
        mem_grant = wb.mem_valid && !wb.alu_valid;
      end else begin
        mem_grant = wb.mem_valid;
        alu_grant = wb.alu_valid && !wb.mem_valid;
      end
    end
    if (alu_grant)
      wait_nxt = '0;
    else if (wb.alu_valid && wait_cnt != WAIT_LIMIT)
      wait_nxt = wait_cnt + 1'b1;
    if (state == MEM_PRI) begin
      if (wait_nxt == WAIT_LIMIT)
        state_nxt = ALU_PRI;
    end else if (alu_grant) begin
      state_nxt = MEM_PRI;
    end
  end

  assign xfer      = alu_grant || mem_grant;
  assign xfer_addr = alu_grant ? wb.alu_addr : wb.mem_addr;
  assign xfer_data = alu_grant ? wb.alu_data : wb.mem_data;

  // Claim is applied after the clear so a same-register claim keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (xfer)
      busy_nxt[xfer_addr] = 1'b0;
    if (wb.claim_valid)
      busy_nxt[wb.claim_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      wb.rd_wen  <= 1'b0;
      wb.rd_addr <= '0;
      wb.rd_data <= '0;
    end else begin
      busy      <= busy_nxt;
      wb.rd_wen <= xfer && (xfer_addr != '0);
      if (xfer && (xfer_addr != '0)) begin
        wb.rd_addr <= xfer_addr;
        wb.rd_data <= xfer_data;
      end
    end
  end

  assign wb.alu_ready = alu_grant;
  assign wb.mem_ready = mem_grant;
  assign wb.rs1_busy  = busy[wb.rs1_addr];
  assign wb.rs2_busy  = busy[wb.rs2_addr];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .MAX_WAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write the DUT presents must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.rd_wen) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(bus.rd_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.rd_addr), 32'(e.addr));
        chk("wr_data", bus.rd_data, e.data);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.alu_valid   = 1'b1;
    bus.alu_addr    = 5'd1;
    bus.alu_data    = 32'h1111_0001;
    bus.mem_valid   = 1'b1;
    bus.mem_addr    = 5'd2;
    bus.mem_data    = 32'hAAAA_0002;
    bus.claim_valid = 1'b0;
    bus.claim_addr  = 5'd0;
    bus.rs1_addr    = 5'd0;
    bus.rs2_addr    = 5'd0;

    // 1: reset holds readies low, release gives mem the first grant
    #3;
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_rd_wen", 32'(bus.rd_wen), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_clk_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_clk_rd_wen", 32'(bus.rd_wen), 32'd0);
    rst = 1'b0;
    #1;
    chk("t1_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("t1_alu_ready", 32'(bus.alu_ready), 32'd0);
    exp_q.push_back('{5'd2, 32'hAAAA_0002});
    next_cycle();
    bus.mem_valid = 1'b0;

    // 2: lone ALU write, one-cycle latency, wen drops after
    bus.alu_addr = 5'd5;
    bus.alu_data = 32'hDEAD_BEEF;
    #1;
    chk("t2_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("t2_mem_ready", 32'(bus.mem_ready), 32'd0);
    exp_q.push_back('{5'd5, 32'hDEAD_BEEF});
    next_cycle();
    bus.alu_valid = 1'b0;
    chk("t2_rd_wen", 32'(bus.rd_wen), 32'd1);
    chk("t2_rd_addr", 32'(bus.rd_addr), 32'd5);
    next_cycle();
    chk("t2_rd_wen_off", 32'(bus.rd_wen), 32'd0);
    chk("t2_rd_addr_hold", 32'(bus.rd_addr), 32'd5);
    chk("t2_rd_data_hold", bus.rd_data, 32'hDEAD_BEEF);

    // 3: both valid continuously; alu wins every fourth cycle
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd9;
    bus.alu_data  = 32'h0000_0099;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 5'd10;
    for (int c = 0; c < 8; c++) begin
      bus.mem_data = 32'h100 + 32'(c);
      #1;
      if (c == 3 || c == 7) begin
        chk($sformatf("t3_alu_ready_c%0d", c), 32'(bus.alu_ready), 32'd1);
        chk($sformatf("t3_mem_ready_c%0d", c), 32'(bus.mem_ready), 32'd0);
        exp_q.push_back('{5'd9, 32'h0000_0099});
      end else begin
        chk($sformatf("t3_alu_ready_c%0d", c), 32'(bus.alu_ready), 32'd0);
        chk($sformatf("t3_mem_ready_c%0d", c), 32'(bus.mem_ready), 32'd1);
        exp_q.push_back('{5'd10, 32'h100 + 32'(c)});
      end
      next_cycle();
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    next_cycle();

    // 4: claim x7, busy until the write of x7 lands
    bus.rs1_addr    = 5'd7;
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd7;
    #1;
    chk("t4_busy_before", 32'(bus.rs1_busy), 32'd0);
    next_cycle();
    bus.claim_valid = 1'b0;
    chk("t4_busy_claimed", 32'(bus.rs1_busy), 32'd1);
    next_cycle();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd7;
    bus.alu_data  = 32'h0000_0077;
    #1;
    chk("t4_busy_xfer_cycle", 32'(bus.rs1_busy), 32'd1);
    exp_q.push_back('{5'd7, 32'h0000_0077});
    next_cycle();
    bus.alu_valid = 1'b0;
    chk("t4_busy_cleared", 32'(bus.rs1_busy), 32'd0);
    chk("t4_rd_wen", 32'(bus.rd_wen), 32'd1);
    chk("t4_rd_addr", 32'(bus.rd_addr), 32'd7);
    bus.claim_valid = 1'b1;
    next_cycle();
    bus.alu_valid = 1'b1;
    bus.alu_data  = 32'h0000_0777;
    exp_q.push_back('{5'd7, 32'h0000_0777});
    next_cycle();
    bus.claim_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    chk("t4_claim_beats_clear", 32'(bus.rs1_busy), 32'd1);
    bus.alu_valid = 1'b1;
    bus.alu_data  = 32'h0000_7777;
    exp_q.push_back('{5'd7, 32'h0000_7777});
    next_cycle();
    bus.alu_valid = 1'b0;
    chk("t4_busy_final", 32'(bus.rs1_busy), 32'd0);

    // 5: write to x0 handshakes but never reaches the port; x0 never busy
    next_cycle();
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd0;
    bus.alu_data  = 32'h0000_1234;
    #1;
    chk("t5_alu_ready", 32'(bus.alu_ready), 32'd1);
    next_cycle();
    bus.alu_valid = 1'b0;
    chk("t5_rd_wen", 32'(bus.rd_wen), 32'd0);
    chk("t5_rd_data_hold", bus.rd_data, 32'h0000_7777);
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd0;
    bus.rs2_addr    = 5'd0;
    next_cycle();
    bus.claim_valid = 1'b0;
    chk("t5_rs2_busy_x0", 32'(bus.rs2_busy), 32'd0);

    // 6: async reset mid-stream clears outputs and scoreboard immediately
    bus.claim_valid = 1'b1;
    bus.claim_addr  = 5'd3;
    bus.alu_valid   = 1'b1;
    bus.alu_addr    = 5'd4;
    bus.alu_data    = 32'h0000_0044;
    exp_q.push_back('{5'd4, 32'h0000_0044});
    next_cycle();
    bus.claim_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.rs1_addr    = 5'd3;
    @(negedge clk);
    #1;
    chk("t6_pre_rd_wen", 32'(bus.rd_wen), 32'd1);
    chk("t6_pre_busy", 32'(bus.rs1_busy), 32'd1);
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rd_wen", 32'(bus.rd_wen), 32'd0);
    chk("t6_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("t6_rd_data", bus.rd_data, 32'd0);
    chk("t6_busy", 32'(bus.rs1_busy), 32'd0);
    chk("t6_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("t6_mem_ready", 32'(bus.mem_ready), 32'd0);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
